if_fetch_unit: RTL and testbench

Instruction-fetch stage that produces the `if_pc` / `if_inst` pair consumed by the IF/ID pipeline register. It honours the same `stop` (stall) and `jump` (redirect/flush) controls that the register sees. It issues pipelined requests to instruction memory and buffers returned words in a small in-order FIFO. On a redirect it discards every stale word, both buffered and in flight.

---
 rtl/if_fetch_unit.sv | 115 +++++++++++
 tb/tb_if_fetch_unit.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: pipelined instruction-memory requests feeding a small in-order
// {pc, inst} FIFO that supplies if_pc/if_inst to the IF/ID register, with stall and redirect.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stop,
    input  logic        jump,
    input  logic [31:0] jump_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic        if_valid
);

    localparam int unsigned PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW  = $clog2(DEPTH + 1);
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [31:0]   fetch_pc;
    logic [31:0]   resp_pc;
    logic [31:0]   last_pc;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] discard;
    logic [31:0]   fifo_pc   [DEPTH];
    logic [31:0]   fifo_inst [DEPTH];

    logic          pop;
    logic          credit;
    logic          accept;
    logic          resp_ok;
    logic          push;
    logic          drop;
    logic [CW:0]   load;
    logic [CW-1:0] inflight;

    assign if_valid  = (count != '0);
    assign if_pc     = if_valid ? fifo_pc[rd_ptr] : last_pc;
    assign if_inst   = if_valid ? fifo_inst[rd_ptr] : NOP;
    assign imem_addr = fetch_pc;

    // Credit counts every word that is buffered or still owed by memory, stale or not.
    always_comb begin
        pop      = if_valid & ~stop & ~jump;
        load     = (CW+1)'(count) + (CW+1)'(outstanding) - (CW+1)'(pop);
        credit   = load < (CW+1)'(DEPTH);
        imem_req = ~reset & ~jump & credit;
        accept   = imem_req & imem_gnt;
        resp_ok  = imem_rvalid & (outstanding != '0);
        push     = resp_ok & ~jump & (discard == '0);
        drop     = resp_ok & ~jump & (discard != '0);
        inflight = outstanding - CW'(resp_ok);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            last_pc     <= RESET_PC;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            outstanding <= '0;
            discard     <= '0;
        end else if (jump) begin
            // Every word still in flight after this cycle belongs to the old path.
            fetch_pc    <= {jump_target[31:2], 2'b00};
            resp_pc     <= {jump_target[31:2], 2'b00};
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            outstanding <= inflight;
            discard     <= inflight;
        end else begin
            if (accept) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
            if (push) begin
                wr_ptr  <= wr_ptr + PW'(1);
                resp_pc <= resp_pc + 32'd4;
            end
            if (pop) begin
                rd_ptr  <= rd_ptr + PW'(1);
                last_pc <= fifo_pc[rd_ptr];
            end
            count       <= count + CW'(push) - CW'(pop);
            outstanding <= outstanding + CW'(accept) - CW'(resp_ok);
            discard     <= discard - CW'(drop);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && push) begin
            fifo_pc[wr_ptr]   <= resp_pc;
            fifo_inst[wr_ptr] <= imem_rdata;
        end
    end

    // A response with nothing outstanding is a memory protocol violation.
    always_ff @(posedge clk) begin
        if (!reset && imem_rvalid) begin
            assert (outstanding != '0);
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Randomized bench for if_fetch_unit: a memory model with variable in-order latency and a
// scoreboard of the expected {pc, inst} stream, checked by a separate output monitor.
module tb_if_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam logic [31:0] KEY      = 32'h1357_9BDF;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stop = 1'b0;
    logic        jump = 1'b0;
    logic [31:0] jump_target = '0;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_valid;

    if_fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk(clk),
        .reset(reset),
        .stop(stop),
        .jump(jump),
        .jump_target(jump_target),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid),
        .imem_rdata(imem_rdata),
        .if_pc(if_pc),
        .if_inst(if_inst),
        .if_valid(if_valid)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          since_reset = 0;
    bit          bubble_chk = 1'b0;
    bit          prev_pending = 1'b0;
    bit          reset_chk = 1'b0;
    logic [31:0] prev_addr = '0;
    logic [31:0] exp_pc = RESET_PC;
    logic [31:0] last_pc = RESET_PC;
    logic [63:0] exp_q [$];
    int          mem_rdy [$];
    logic [31:0] mem_addr [$];
    int          last_rdy = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ KEY;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock cycle: drive inputs after the falling edge, then update the model.
    task automatic step(input logic r, input logic s, input logic j, input logic g,
                        input logic [31:0] tgt, input int lat);
        int rdy;
        @(negedge clk);
        cyc++;
        reset       = r;
        stop        = s;
        jump        = j;
        jump_target = tgt;
        imem_gnt    = g;
        if (!r && mem_rdy.size() > 0 && mem_rdy[0] <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(mem_addr[0]);
            void'(mem_rdy.pop_front());
            void'(mem_addr.pop_front());
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom();
        end
        #1;
        if (reset_chk && !r) begin
            check("reset_if_valid", 32'(if_valid), 32'd0);
            check("reset_if_inst", if_inst, NOP);
            check("reset_if_pc", if_pc, RESET_PC);
            check("reset_imem_addr", imem_addr, RESET_PC);
        end
        reset_chk = r;
        if (prev_pending && !r && !j) begin
            check("req_hold", 32'(imem_req), 32'd1);
            check("addr_hold", imem_addr, prev_addr);
        end
        if (r || j) begin
            check("req_low_on_reset_or_jump", 32'(imem_req), 32'd0);
        end
        if (bubble_chk && !r && since_reset >= 2) begin
            check("no_bubble", 32'(if_valid), 32'd1);
        end
        if (r) begin
            exp_q.delete();
            mem_rdy.delete();
            mem_addr.delete();
            last_rdy    = 0;
            exp_pc      = RESET_PC;
            since_reset = 0;
        end else begin
            since_reset++;
            if (j) begin
                exp_q.delete();
                exp_pc = tgt;
            end else if (imem_req && g) begin
                check("imem_addr", imem_addr, exp_pc);
                exp_q.push_back({exp_pc, mem_word(exp_pc)});
                rdy = (cyc + lat > last_rdy + 1) ? cyc + lat : last_rdy + 1;
                mem_rdy.push_back(rdy);
                mem_addr.push_back(exp_pc);
                last_rdy = rdy;
                exp_pc   = exp_pc + 32'd4;
            end
        end
        prev_pending = imem_req && !g && !r && !j;
        prev_addr    = imem_addr;
    endtask

    // Output monitor: every consumed head must match the next expected fetch.
    initial begin
        logic [63:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (reset) begin
                last_pc = RESET_PC;
            end else if (if_valid) begin
                if (!stop && !jump) begin
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_output: got pc %h with nothing expected (cycle %0d)",
                                 if_pc, cyc);
                    end else begin
                        e = exp_q.pop_front();
                        check("if_pc", if_pc, e[63:32]);
                        check("if_inst", if_inst, e[31:0]);
                        last_pc = e[63:32];
                    end
                end
            end else begin
                check("empty_nop", if_inst, NOP);
                check("empty_pc", if_pc, last_pc);
            end
        end
    end

    initial begin
        logic [31:0] tgt;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1);

        // Sustained streaming with a stall in the middle.
        bubble_chk = 1'b1;
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 1);
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 1);
            if (k >= 3) check("stop_req_drop", 32'(imem_req), 32'd0);
        end
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 1);
        bubble_chk = 1'b0;

        // Grant withheld: request holds, FIFO drains to NOP.
        for (int k = 0; k < 6; k++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1);
            if (k == 5) begin
                check("drain_valid", 32'(if_valid), 32'd0);
                check("drain_req", 32'(imem_req), 32'd1);
            end
        end

        // Redirect with stale words in flight under 3-cycle latency.
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 3);
        step(1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0100, 3);
        for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 3);

        // Jump and stop together behave as a jump.
        step(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0200, 1);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 1);

        // Fetch PC wraps past the top of the address space.
        step(1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFF8, 1);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 1);

        // Reset with the FIFO partly full and a request outstanding.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 1);
        step(1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 1);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 1);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            tgt = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 : ($urandom() & 32'h0000_FFFC);
            step(1'($urandom_range(0, 199) == 0),
                 1'($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 19) == 0),
                 1'($urandom_range(0, 9) < 7),
                 tgt,
                 int'($urandom_range(1, 4)));
        end

        // No new grants: every expected word must come out.
        for (int i = 0; i < 25; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1);
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
